// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and capture FSM state encoding.
package vga_pkg;

  localparam int unsigned H_VISIBLE_DEF   = 640;
  localparam int unsigned H_FP_DEF        = 16;
  localparam int unsigned H_SYNC_DEF      = 96;
  localparam int unsigned H_BP_DEF        = 48;
  localparam int unsigned V_VISIBLE_DEF   = 480;
  localparam int unsigned V_FP_DEF        = 10;
  localparam int unsigned V_SYNC_DEF      = 2;
  localparam int unsigned V_BP_DEF        = 33;
  localparam int unsigned LOCK_FRAMES_DEF = 2;

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StMeasure = 2'd1,
    StLocked  = 2'd2
  } state_e;

endpackage

// File: rtl/vga_crc16.sv
// One CRC-16-CCITT (poly 0x1021) step over a 12-bit word, MSB first.
module vga_crc16 (
  input  logic [15:0] crc_in,
  input  logic [11:0] data,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 11; i >= 0; i--) begin
      if (crc_out[15] ^ data[i]) begin
        crc_out = {crc_out[14:0], 1'b0} ^ 16'h1021;
      end else begin
        crc_out = {crc_out[14:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/vga_capture.sv
// VGA timing recovery and pixel capture with lock FSM and error counting.
// Define VGA_CAPTURE_CRC_EN to build the per-frame CRC-16 of captured pixels.
module vga_capture
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
  parameter int unsigned H_FP        = H_FP_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BP        = H_BP_DEF,
  parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
  parameter int unsigned V_FP        = V_FP_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BP        = V_BP_DEF,
  parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pixel_tick,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic [11:0] vga_rgb,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_done,
  output logic        locked,
  output logic        sync_err,
  output logic [7:0]  err_count,
  output logic [15:0] frame_crc
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_TMO_M1 = 11'(2 * H_TOTAL - 1);
  localparam logic [10:0] H_START  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END    = 11'(H_SYNC + H_BP + H_VISIBLE - 1);
  localparam logic [10:0] V_START  = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_END    = 11'(V_SYNC + V_BP + V_VISIBLE - 1);
  localparam logic [9:0]  X_LAST   = 10'(H_VISIBLE - 1);
  localparam logic [9:0]  Y_LAST   = 10'(V_VISIBLE - 1);
  localparam logic [7:0]  GOOD_REQ = 8'(LOCK_FRAMES);

  state_e      state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic        hs_prev_q, vs_prev_q;
  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        pix_valid_q, frame_done_q, sync_err_q;
  logic [9:0]  pix_x_q, pix_y_q;
  logic [11:0] pix_rgb_q;
  logic [7:0]  err_cnt_q;

  logic        hs_fall, vs_fall, line_err, frame_err, timeout, in_win, emit, err_pulse, last_pix;
  logic [9:0]  px, py;

  always_comb begin
    hs_fall = pixel_tick & hs_prev_q & ~vga_hsync;
    vs_fall = pixel_tick & vs_prev_q & ~vga_vsync;

    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pixel_tick) begin
      if (hs_fall) h_cnt_d = '0;
      else if (h_cnt_q != 11'h7FF) h_cnt_d = h_cnt_q + 11'd1;
      if (vs_fall) v_cnt_d = '0;
      else if (hs_fall && v_cnt_q != 11'h7FF) v_cnt_d = v_cnt_q + 11'd1;
    end

    // Errors are judged on the count before this tick's update.
    line_err  = hs_fall && (h_cnt_q != H_LAST);
    frame_err = vs_fall && (v_cnt_q != V_LAST);
    timeout   = pixel_tick && !hs_fall && (h_cnt_q == H_TMO_M1);

    // Pixel position is that of the sample taken on this tick.
    in_win   = (h_cnt_d >= H_START) && (h_cnt_d <= H_END) &&
               (v_cnt_d >= V_START) && (v_cnt_d <= V_END);
    emit     = pixel_tick && (state_q == StLocked) && in_win &&
               !line_err && !frame_err && !timeout;
    px       = 10'(h_cnt_d - H_START);
    py       = 10'(v_cnt_d - V_START);
    last_pix = (px == X_LAST) && (py == Y_LAST);
  end

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    err_pulse = 1'b0;
    case (state_q)
      StSearch: begin
        if (vs_fall) begin
          state_d = StMeasure;
          good_d  = '0;
        end
      end
      StMeasure, StLocked: begin
        if (timeout) begin
          err_pulse = 1'b1;
          state_d   = StSearch;
          good_d    = '0;
        end else if (line_err || frame_err) begin
          err_pulse = 1'b1;
          state_d   = StMeasure;
          good_d    = '0;
        end else if (vs_fall && state_q == StMeasure) begin
          good_d = good_q + 8'd1;
          if (good_d == GOOD_REQ) state_d = StLocked;
        end
      end
      default: begin
        state_d = StSearch;
        good_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StSearch;
      good_q       <= '0;
      hs_prev_q    <= 1'b1;
      vs_prev_q    <= 1'b1;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_rgb_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      if (pixel_tick) begin
        hs_prev_q <= vga_hsync;
        vs_prev_q <= vga_vsync;
      end
      state_q      <= state_d;
      good_q       <= good_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      pix_valid_q  <= emit;
      frame_done_q <= emit && last_pix;
      sync_err_q   <= err_pulse;
      if (err_pulse && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      if (emit) begin
        pix_x_q   <= px;
        pix_y_q   <= py;
        pix_rgb_q <= vga_rgb;
      end
    end
  end

  assign pix_valid  = pix_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_rgb    = pix_rgb_q;
  assign err_count  = err_cnt_q;
  assign locked     = (state_q == StLocked);

`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] crc_q, crc_seed, crc_next, frame_crc_q;

  assign crc_seed = (px == 10'd0 && py == 10'd0) ? 16'hFFFF : crc_q;

  vga_crc16 u_crc (
    .crc_in  (crc_seed),
    .data    (vga_rgb),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q       <= '0;
      frame_crc_q <= '0;
    end else if (emit) begin
      crc_q <= crc_next;
      if (last_pix) frame_crc_q <= crc_next;
    end
  end

  assign frame_crc = frame_crc_q;
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture using a shrunken 16x11-tick raster.
module tb_vga_capture;

  localparam int HV = 8, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6, VF = 1, VS = 2, VB = 2;
  localparam int LT = HV + HF + HS + HB;  // 16 ticks per line
  localparam int VT = VV + VF + VS + VB;  // 11 lines per frame
  localparam int HST = HS + HB;
  localparam int VST = VS + VB;

  logic        clk, reset_n, pixel_tick, vga_hsync, vga_vsync;
  logic [11:0] vga_rgb;
  logic        pix_valid, frame_done, locked, sync_err;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] pix_rgb;
  logic [7:0]  err_count;
  logic [15:0] frame_crc;

  vga_capture #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .LOCK_FRAMES(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pixel_tick (pixel_tick),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .vga_rgb    (vga_rgb),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err),
    .err_count  (err_count),
    .frame_crc  (frame_crc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
    logic        fd;
  } pix_t;

  pix_t        exp_q[$];
  int          total = 0, bad = 0;
  int          pix_cnt = 0, fd_cnt = 0, err_pulses = 0;
  logic [11:0] fd_rgb = '0;
  logic [15:0] zero_gold;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) r = (r[15] ^ d[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  // Monitor: every presented pixel is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (sync_err) err_pulses++;
    if (pix_valid) begin
      pix_cnt++;
      if (frame_done) begin
        fd_cnt++;
        fd_rgb = pix_rgb;
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pix: got x=%0d y=%0d rgb=%0h required none", pix_x, pix_y,
                 pix_rgb);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        check("pix", {pix_x, pix_y, pix_rgb, frame_done}, e);
      end
    end else if (frame_done) begin
      total++;
      bad++;
      $display("FAIL fd_without_valid: got frame_done=1 required 0");
    end
  end

  task automatic tick(input logic hs, input logic vs, input logic [11:0] rgb);
    @(negedge clk);
    vga_hsync  = hs;
    vga_vsync  = vs;
    vga_rgb    = rgb;
    pixel_tick = 1'b1;
    @(negedge clk);
    pixel_tick = 1'b0;
  endtask

  task automatic drive_line(input int v, input int h0, input int h1, input bit emit,
                            input bit ramp);
    int          x, y;
    bit          vis;
    logic [11:0] rgb;
    pix_t        e;
    for (int h = h0; h < h1; h++) begin
      x   = h - HST;
      y   = v - VST;
      vis = (h >= HST) && (h < HST + HV) && (v >= VST) && (v < VST + VV);
      if (vis) rgb = ramp ? {x[3:0], 4'h0, y[3:0]} : 12'h000;
      else rgb = 12'h5A5;
      if (emit && vis) begin
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.rgb = rgb;
        e.fd  = (x == HV - 1) && (y == VV - 1);
        exp_q.push_back(e);
      end
      tick(h >= HS, v >= VS, rgb);
    end
  endtask

  // emit_last: last line index whose visible pixels are expected (-1 for none).
  task automatic drive_frame(input int emit_last, input bit ramp, input int long_line);
    for (int v = 0; v < VT; v++) begin
      if (long_line >= 0 && v == long_line + 1) begin
        drive_line(v, 0, 1, v <= emit_last, ramp);
        check("err_pulse_next_clk", sync_err, 1);
        check("unlock_next_clk", locked, 0);
        drive_line(v, 1, LT, v <= emit_last, ramp);
      end else begin
        drive_line(v, 0, (v == long_line) ? LT + 1 : LT, v <= emit_last, ramp);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    zero_gold = 16'hFFFF;
    for (int i = 0; i < HV * VV; i++) zero_gold = crc_ref(zero_gold, 12'h000);

    reset_n    = 1'b0;
    pixel_tick = 1'b0;
    vga_hsync  = 1'b1;
    vga_vsync  = 1'b1;
    vga_rgb    = '0;
    repeat (3) @(negedge clk);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_locked", locked, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_pix_xy_rgb", {pix_x, pix_y, pix_rgb}, 0);
    check("rst_err_count", err_count, 0);
    check("rst_frame_crc", frame_crc, 0);
    reset_n = 1'b1;

    // Acquisition: lock arrives on the third VSYNC fall.
    drive_frame(-1, 1, -1);
    drive_frame(-1, 1, -1);
    check("unlocked_after_2_falls", locked, 0);
    check("no_pix_while_unlocked", pix_cnt, 0);
    drive_frame(VT - 1, 1, -1);
    check("locked_after_3_falls", locked, 1);
    check("pix_count_frame", pix_cnt, HV * VV);
    check("frame_done_count", fd_cnt, 1);
    check("ramp_last_rgb", fd_rgb, 12'h705);
    check("no_err_clean", err_count, 0);

    // Two all-zero frames: CRC must match and hold steady.
    drive_frame(VT - 1, 0, -1);
`ifdef VGA_CAPTURE_CRC_EN
    check("crc_zero_frame", frame_crc, zero_gold);
`else
    check("crc_disabled", frame_crc, 16'h0000);
`endif
    drive_frame(VT - 1, 0, -1);
`ifdef VGA_CAPTURE_CRC_EN
    check("crc_zero_frame_repeat", frame_crc, zero_gold);
`else
    check("crc_disabled_repeat", frame_crc, 16'h0000);
`endif

    // One over-long line while locked, then relock after two good falls.
    pix_cnt    = 0;
    fd_cnt     = 0;
    err_pulses = 0;
    drive_frame(5, 1, 5);
    check("long_line_err_count", err_count, 1);
    check("long_line_err_pulses", err_pulses, 1);
    check("long_line_pix_count", pix_cnt, 2 * HV);
    check("long_line_no_fd", fd_cnt, 0);
    drive_frame(-1, 1, -1);
    check("relock_pending", locked, 0);
    drive_frame(VT - 1, 1, -1);
    check("relocked", locked, 1);
    check("relock_err_count", err_count, 1);

    // HSYNC stalls: timeout drops to SEARCH, so a full reacquisition is needed.
    pix_cnt    = 0;
    err_pulses = 0;
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b1, 12'hFFF);
    check("timeout_pulse", err_pulses, 1);
    check("timeout_err_count", err_count, 2);
    check("timeout_unlocked", locked, 0);
    check("timeout_no_pix", pix_cnt, 0);
    drive_frame(-1, 1, -1);
    drive_frame(-1, 1, -1);
    check("search_after_timeout", locked, 0);
    check("search_ignores_err", err_count, 2);
    drive_frame(VT - 1, 1, -1);
    check("locked_after_timeout", locked, 1);

    // Reset mid-line while locked.
    for (int v = 0; v < 6; v++) drive_line(v, 0, LT, 1'b1, 1'b1);
    drive_line(6, 0, 9, 1'b1, 1'b1);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_locked", locked, 0);
    check("midrst_flags", {pix_valid, frame_done, sync_err}, 0);
    check("midrst_pix_xy_rgb", {pix_x, pix_y, pix_rgb}, 0);
    check("midrst_err_count", err_count, 0);
    check("midrst_frame_crc", frame_crc, 0);
    @(negedge clk);
    reset_n = 1'b1;
    pix_cnt = 0;
    for (int v = 7; v < VT; v++) drive_line(v, 0, LT, 1'b0, 1'b1);
    drive_frame(-1, 1, -1);
    drive_frame(-1, 1, -1);
    check("midrst_not_locked_2", locked, 0);
    check("midrst_no_pix", pix_cnt, 0);
    drive_frame(VT - 1, 1, -1);
    check("midrst_relocked", locked, 1);
    check("midrst_pix_count", pix_cnt, HV * VV);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
- REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
- REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in ticks.
- REQ-003 SHALL have parameter H_SYNC, default 96, HSYNC pulse width in ticks.
- REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in ticks.
- REQ-005 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
- REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
- REQ-007 SHALL have parameter V_SYNC, default 2, VSYNC pulse width in lines.
- REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
- REQ-009 SHALL have parameter LOCK_FRAMES, default 2, consecutive good frames needed to lock.
- REQ-010 SHALL have port clk, input, 1 bit: the single clock. Every flop SHALL be in this domain.
- REQ-011 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
- REQ-012 SHALL have port pixel_tick, input, 1 bit: sample enable, one pixel per asserted clk.
- REQ-013 SHALL have port vga_hsync, input, 1 bit: horizontal sync, active-low.
- REQ-014 SHALL have port vga_vsync, input, 1 bit: vertical sync, active-low.
- REQ-015 SHALL have port vga_rgb, input, 12 bits: pixel colour {R,G,B} 4 bits each.
- REQ-016 SHALL have port pix_valid, output, 1 bit: recovered visible pixel strobe.
- REQ-017 SHALL have port pix_x, output, 10 bits: recovered column.
- REQ-018 SHALL have port pix_y, output, 10 bits: recovered row.
- REQ-019 SHALL have port pix_rgb, output, 12 bits: captured colour.
- REQ-020 SHALL have port frame_done, output, 1 bit: last visible pixel of a frame.
- REQ-021 SHALL have port locked, output, 1 bit: timing lock status.
- REQ-022 SHALL have port sync_err, output, 1 bit: one-clk pulse on a timing error.
- REQ-023 SHALL have port err_count, output, 8 bits: error counter, saturates at 255.
- REQ-024 SHALL have port frame_crc, output, 16 bits: CRC of the last complete frame.

Function
- REQ-025 SHALL sample hsync, vsync and rgb only on clk edges where pixel_tick=1; nothing advances otherwise.
- REQ-026 Falling edge SHALL be detected as: previous sample 1, current sample 0. Counting is in ticks.
- REQ-027 h_cnt (11-bit) SHALL be set to 0 on an HSYNC-fall tick, SHALL increment on every other tick, and SHALL saturate at 2047.
- REQ-028 On an HSYNC-fall tick, v_cnt SHALL increment. On a VSYNC-fall tick, v_cnt SHALL be set to 0; if both fall on the same tick, VSYNC wins.
- REQ-029 Line error: at an HSYNC-fall tick, prior h_cnt != H_TOTAL-1, where H_TOTAL is the sum of the four H_* parameters (800).
- REQ-030 Frame error: at a VSYNC-fall tick, prior v_cnt != V_TOTAL-1, where V_TOTAL is the sum of the four V_* parameters (525).
- REQ-031 Timeout: h_cnt reaches 2*H_TOTAL.
- REQ-032 FSM SEARCH SHALL go to MEASURE on the first VSYNC fall and clear good_frames; errors in SEARCH SHALL be ignored.
- REQ-033 FSM MEASURE SHALL increment good_frames at each error-free VSYNC fall and go to LOCKED when good_frames reaches LOCK_FRAMES.
- REQ-034 FSM LOCKED: locked=1.
- REQ-035 Any line error or frame error in MEASURE or LOCKED SHALL pulse sync_err, increment err_count, go to MEASURE and clear good_frames.
- REQ-036 A timeout in MEASURE or LOCKED SHALL pulse sync_err, increment err_count and go to SEARCH.
- REQ-037 Visible window: h_cnt in [H_SYNC+H_BP, +H_VISIBLE-1] and v_cnt in [V_SYNC+V_BP, +V_VISIBLE-1].
- REQ-038 When locked and in the visible window, pix_valid SHALL assert for exactly one clk, the clk after the sampling tick.
- REQ-039 With pix_valid: pix_x = h_cnt-(H_SYNC+H_BP), pix_y = v_cnt-(V_SYNC+V_BP), pix_rgb = sampled rgb.
- REQ-040 frame_done SHALL assert in the same clk as pix_valid for (H_VISIBLE-1, V_VISIBLE-1).
- REQ-041 locked SHALL drop in the clk after the error tick. A pixel on the error tick SHALL NOT be emitted.

Reset
- REQ-042 reset_n=0 SHALL force state SEARCH with all counters 0.
- REQ-043 reset_n=0 SHALL force outputs pix_valid, frame_done, locked and sync_err to 0.
- REQ-044 reset_n=0 SHALL force outputs pix_x, pix_y, pix_rgb, err_count and frame_crc to 0.
- REQ-045 Edge-detect history SHALL reset to 1 (idle syncs), so no false fall after reset.
- REQ-046 Reset mid-frame SHALL require a full re-lock of (LOCK_FRAMES+1) VSYNC falls.

Configuration
- REQ-047 With VGA_CAPTURE_CRC_EN defined, the CRC SHALL be CRC-16-CCITT (poly 0x1021, init 0xFFFF), fed 12 bits per emitted pixel, MSB first.
- REQ-048 With VGA_CAPTURE_CRC_EN defined, the CRC SHALL be reinitialised on pixel (0,0) and copied into frame_crc on the frame_done clk.
- REQ-049 Without VGA_CAPTURE_CRC_EN, frame_crc SHALL be constant 16'h0000 and no CRC logic SHALL be built.

Structure
- REQ-050 Package vga_pkg SHALL hold the 640x480 timing constants and the FSM state encoding.
- REQ-051 One sub-module vga_crc16 SHALL be used: a combinational 12-bit-input CRC step, instantiated only under VGA_CAPTURE_CRC_EN.

Verification
- REQ-052 Drive 3 clean 800x525 frames with a tick every 2 clk -> locked=1 after the 3rd VSYNC fall.
- REQ-053 Drive 3 clean 800x525 frames with a tick every 2 clk -> exactly 307200 pix_valid and one frame_done per locked frame.
- REQ-054 While locked, a ramp image rgb = x[3:0]<<8 | y[3:0] -> pix_rgb matches at pix (639,479) = 12'hF0F, with frame_done that clk.
- REQ-055 While locked, one 801-tick line -> sync_err pulse, err_count=1, locked=0 next clk, relock after 2 good frames.
- REQ-056 Stop HSYNC toggling for 1600 ticks -> sync_err, state SEARCH, no pix_valid.
- REQ-057 Assert reset_n low mid-line while locked -> all outputs 0 immediately; no pix_valid until re-lock.
- REQ-058 With VGA_CAPTURE_CRC_EN, an all-zero frame -> frame_crc equals the golden-model value, and is stable across repeated frames.
